// File: rtl/da4dac_seq.sv
// da4dac_seq: round-robin scheduler sharing one 4-channel serial DAC core among four requesters.
// Define SEQ_TIMEOUT_EN to abort stalled handshakes and raise the sticky seqerr flag.
module da4dac_seq #(
    parameter logic [3:0]  CMD     = 4'b0011,
    parameter logic [15:0] TIMEOUT = 16'd200,
    parameter logic [3:0]  GAP     = 4'd2
) (
    input  logic        seqclk,
    input  logic        seqreset,
    input  logic [3:0]  seqreq,
    input  logic [47:0] seqdata,
    output logic [3:0]  seqack,
    output logic        seqbusy,
    output logic        seqerr,
    output logic        dacdav,
    input  logic        davdac,
    output logic [3:0]  daccmd,
    output logic [3:0]  dacaddr,
    output logic [11:0] dacdata,
    output logic [7:0]  dacaux
);
    typedef enum logic [1:0] {IDLE, SEND, RELEASE, GAPS} state_t;
    localparam state_t AFTER = (GAP == 4'd0) ? IDLE : GAPS;
    state_t state, state_n;
    logic [1:0] last, pick;
    logic [3:0] gcnt;
    logic abort;
    assign daccmd  = CMD;
    assign dacaux  = 8'h00;
    assign seqbusy = state != IDLE;
    // Walk downward so the nearest channel after last wins.
    always_comb begin
        pick = last;
        for (int i = 4; i >= 1; i--)
            if (seqreq[last + 2'(i)]) pick = last + 2'(i);
    end
`ifdef SEQ_TIMEOUT_EN
    logic [15:0] tcnt;
    assign abort = tcnt == TIMEOUT - 16'd1 && (state == SEND ? !davdac : state == RELEASE && davdac);
    always_ff @(posedge seqclk or posedge seqreset) begin
        if (seqreset) begin
            tcnt   <= '0;
            seqerr <= 1'b0;
        end else begin
            tcnt <= state_n != state ? 16'd0 : tcnt + 16'd1;
            if (abort) seqerr <= 1'b1;
        end
    end
`else
    assign abort  = TIMEOUT == 16'd0 && 1'b0;
    assign seqerr = 1'b0;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |seqreq && !davdac ? SEND : IDLE;
            SEND:    state_n = davdac ? RELEASE : abort ? AFTER : SEND;
            RELEASE: state_n = !davdac || abort ? AFTER : RELEASE;
            GAPS:    state_n = gcnt == GAP - 4'd1 ? IDLE : GAPS;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge seqclk or posedge seqreset) begin
        if (seqreset) begin
            state   <= IDLE;
            last    <= 2'd3;
            gcnt    <= '0;
            dacdav  <= 1'b0;
            seqack  <= '0;
            dacaddr <= '0;
            dacdata <= '0;
        end else begin
            state  <= state_n;
            gcnt   <= state == GAPS ? gcnt + 4'd1 : 4'd0;
            seqack <= state == RELEASE && !davdac ? 4'b0001 << dacaddr[1:0] : 4'b0000;
            if (state == IDLE && state_n == SEND) begin
                last    <= pick;
                dacaddr <= {2'b00, pick};
                dacdata <= seqdata[12*pick +: 12];
                dacdav  <= 1'b1;
            end else if (state == SEND && state_n != SEND)
                dacdav <= 1'b0;
        end
    end
endmodule

// File: tb/tb_da4dac_seq.sv
// tb_da4dac_seq: directed vector bench for da4dac_seq with a behavioural DAC core.
// Build with SEQ_TIMEOUT_EN to exercise the handshake-timeout path.
module tb_da4dac_seq;
    logic        seqclk = 0, seqreset = 0;
    logic [3:0]  seqreq = 0, seqack;
    logic [47:0] seqdata = 0;
    logic        seqbusy, seqerr, dacdav, davdac;
    logic [3:0]  daccmd, dacaddr;
    logic [11:0] dacdata;
    logic [7:0]  dacaux;
    logic        core_dav = 0, force_dav = 0, core_on = 1;
    int          ccnt = 0, dly = 5, cyc = 0, passed = 0, total = 0;

    assign davdac = core_dav | force_dav;
    always #5 seqclk = ~seqclk;
    always @(posedge seqclk) cyc <= cyc + 1;

    da4dac_seq dut (
        .seqclk(seqclk), .seqreset(seqreset), .seqreq(seqreq), .seqdata(seqdata),
        .seqack(seqack), .seqbusy(seqbusy), .seqerr(seqerr), .dacdav(dacdav),
        .davdac(davdac), .daccmd(daccmd), .dacaddr(dacaddr), .dacdata(dacdata),
        .dacaux(dacaux)
    );

    // Core acks dly cycles after dacdav rises and releases once dacdav drops.
    always @(posedge seqclk or posedge seqreset) begin
        if (seqreset) begin
            core_dav <= 0;
            ccnt     <= 0;
        end else if (!dacdav) begin
            core_dav <= 0;
            ccnt     <= 0;
        end else begin
            ccnt <= ccnt + 1;
            if (core_on && ccnt >= dly - 1) core_dav <= 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic xfer(output logic [3:0] a, output logic [11:0] d, output logic [3:0] k,
                        output bit st, output bit dr, output int rc, output int ac);
        int n;
        bit pd;
        a = 0; d = 0; k = 0; st = 0; dr = 0; rc = 0; ac = 0;
        n = 0;
        do begin @(negedge seqclk); n++; end while (!dacdav && n < 50);
        if (!dacdav) begin
            check("dav_rise", dacdav, 1);
            return;
        end
        rc = cyc; a = dacaddr; d = dacdata; st = 1; pd = 0; n = 0;
        while (dacdav && n < 400) begin
            if (dacaddr !== a || dacdata !== d || daccmd !== 4'h3 || dacaux !== 8'h00) st = 0;
            pd = davdac;
            @(negedge seqclk);
            n++;
        end
        dr = pd & !dacdav;
        n = 0;
        while (seqack == 0 && n < 20) begin @(negedge seqclk); n++; end
        k = seqack; ac = cyc;
        @(negedge seqclk);
        check("ack_one_cycle", seqack, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (seqbusy && n < 50) begin @(negedge seqclk); n++; end
        check("back_to_idle", seqbusy, 0);
    endtask

    task automatic do_reset();
        @(negedge seqclk);
        seqreset = 1;
        @(negedge seqclk);
        seqreset = 0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [47:0] data;
        logic [3:0]  addr;
        logic [11:0] exp_d;
        int          dly;
    } vec_t;
    vec_t vt[7];

    initial begin
        logic [3:0] a, k;
        logic [11:0] d;
        bit st, dr;
        int rc, ac, prev_ac, n;
        vt[0] = '{4'b0100, {12'h000, 12'hABC, 12'h000, 12'h000}, 4'h2, 12'hABC, 66};
        vt[1] = '{4'b0011, {12'h000, 12'h000, 12'h222, 12'h111}, 4'h0, 12'h111, 5};
        vt[2] = '{4'b0011, {12'h000, 12'h000, 12'h222, 12'h111}, 4'h1, 12'h222, 5};
        vt[3] = '{4'b0011, {12'h000, 12'h000, 12'h222, 12'h111}, 4'h0, 12'h111, 5};
        vt[4] = '{4'b1001, {12'h333, 12'h000, 12'h000, 12'h444}, 4'h3, 12'h333, 5};
        vt[5] = '{4'b1001, {12'h333, 12'h000, 12'h000, 12'h444}, 4'h0, 12'h444, 5};
        vt[6] = '{4'b1000, {12'h777, 12'h000, 12'h000, 12'h000}, 4'h3, 12'h777, 5};

        @(negedge seqclk);
        seqreset = 1;
        #1;
        check("rst_dav", dacdav, 0);
        check("rst_ack", seqack, 0);
        check("rst_busy", seqbusy, 0);
        check("rst_err", seqerr, 0);
        check("rst_addr", dacaddr, 0);
        check("rst_data", dacdata, 0);
        @(negedge seqclk);
        seqreset = 0;

        for (int i = 0; i < 7; i++) begin
            dly = vt[i].dly;
            seqreq = vt[i].req;
            seqdata = vt[i].data;
            xfer(a, d, k, st, dr, rc, ac);
            seqreq = 0;
            check($sformatf("v%0d_addr", i), a, vt[i].addr);
            check($sformatf("v%0d_data", i), d, vt[i].exp_d);
            check($sformatf("v%0d_ack", i), k, 4'b0001 << vt[i].addr[1:0]);
            check($sformatf("v%0d_stable", i), st, 1);
            check($sformatf("v%0d_drop", i), dr, 1);
            wait_idle();
        end

        // All four held: strict 0,1,2,3,0 rotation with GAP+1 cycles from ack to next dav
        dly = 5;
        do_reset();
        seqdata = {12'h004, 12'h003, 12'h002, 12'h001};
        seqreq = 4'b1111;
        prev_ac = 0;
        for (int j = 0; j < 5; j++) begin
            xfer(a, d, k, st, dr, rc, ac);
            check($sformatf("rr%0d_addr", j), a, j % 4);
            check($sformatf("rr%0d_data", j), d, j % 4 + 1);
            check($sformatf("rr%0d_ack", j), k, 4'b0001 << (j % 4));
            if (j > 0) check($sformatf("rr%0d_gap", j), rc - prev_ac, 3);
            prev_ac = ac;
        end
        seqreq = 0;
        wait_idle();

        // Request withdrawn and data overwritten after grant
        seqdata = {12'h9C3, 36'h0};
        seqreq = 4'b1000;
        n = 0;
        do begin @(negedge seqclk); n++; end while (!dacdav && n < 20);
        @(negedge seqclk);
        seqreq = 0;
        seqdata[47:36] = 12'hFFF;
        xfer(a, d, k, st, dr, rc, ac);
        check("drop_data", d, 12'h9C3);
        check("drop_ack", k, 4'b1000);
        wait_idle();

        // Core still asserting ack while idle blocks any grant
        force_dav = 1;
        seqreq = 4'b0001;
        seqdata = {36'h0, 12'h0AA};
        repeat (5) @(negedge seqclk);
        check("stuck_dav", dacdav, 0);
        check("stuck_busy", seqbusy, 0);
        force_dav = 0;
        xfer(a, d, k, st, dr, rc, ac);
        seqreq = 0;
        check("stuck_addr", a, 4'h0);
        check("stuck_ack", k, 4'b0001);
        wait_idle();

        // Asynchronous reset in the middle of a frame
        dly = 30;
        seqreq = 4'b0010;
        seqdata = {24'h0, 12'h5A5, 12'h0};
        n = 0;
        do begin @(negedge seqclk); n++; end while (!dacdav && n < 20);
        repeat (3) @(negedge seqclk);
        #1 seqreset = 1;
        #1;
        check("mid_rst_dav", dacdav, 0);
        check("mid_rst_ack", seqack, 0);
        check("mid_rst_busy", seqbusy, 0);
        check("mid_rst_addr", dacaddr, 0);
        check("mid_rst_data", dacdata, 0);
        @(negedge seqclk);
        seqreset = 0;
        dly = 5;
        xfer(a, d, k, st, dr, rc, ac);
        seqreq = 0;
        check("post_rst_addr", a, 4'h1);
        check("post_rst_data", d, 12'h5A5);
        check("post_rst_ack", k, 4'b0010);
        check("post_rst_drop", dr, 1);
        wait_idle();

`ifdef SEQ_TIMEOUT_EN
        do_reset();
        core_on = 0;
        seqdata = {24'h0, 12'h0B1, 12'h0B0};
        seqreq = 4'b0011;
        n = 0;
        do begin @(negedge seqclk); n++; end while (!dacdav && n < 20);
        check("to_grant", dacaddr, 4'h0);
        n = 0;
        while (dacdav && n < 300) begin n++; @(negedge seqclk); end
        check("to_dav_len", n, 200);
        check("to_err", seqerr, 1);
        core_on = 1;
        xfer(a, d, k, st, dr, rc, ac);
        seqreq = 0;
        check("to_next_addr", a, 4'h1);
        check("to_next_ack", k, 4'b0010);
        check("to_err_sticky", seqerr, 1);
        wait_idle();
`else
        check("err_tied_low", seqerr, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/da4dac_seq.md
Name: da4dac_seq

Overview:
- Round-robin scheduler that shares the single 4-channel serial DAC core between four requesters.
- Each requester supplies a 12-bit sample. The scheduler latches it and drives the core's dav/ack handshake with command, address and data. It then returns a one-cycle completion pulse to the requester.
- Sits between application logic (waveform generators, control loops) and the DAC serial core.

Parameters:
CMD, 4'b0011, DAC command nibble sent with every write (write-and-update-n)
TIMEOUT, 16'd200, cycles allowed per handshake phase before abort (used only with the optional feature)
GAP, 4'd2, idle cycles enforced between consecutive transactions; 0 is legal

Ports:
seqclk  in  1  clock, shared with the DAC core clock
seqreset  in  1  asynchronous active-high reset
seqreq  in  4  per-channel request, level, held until matching seqack
seqdata  in  48  channel n sample at [12n+11:12n]
seqack  out  4  one-cycle pulse, bit n, when channel n transfer completes
seqbusy  out  1  high in any state other than IDLE
seqerr  out  1  sticky handshake-timeout flag
dacdav  out  1  data-valid to DAC core
davdac  in  1  ack from DAC core; high at end of frame, low after dacdav drops
daccmd  out  4  command to core, constant CMD
dacaddr  out  4  channel address, {2'b00, granted channel}
dacdata  out  12  latched sample of granted channel
dacaux  out  8  constant 8'h00

Behaviour:
- Reset (async, immediate): dacdav=0, seqack=0, seqbusy=0, seqerr=0, dacaddr=0, dacdata=0, state=IDLE, last-served pointer=3 (so channel 0 wins first), gap counter=0.
- dacdav dropping on reset returns the core to its idle state; no frame survives a reset.
- IDLE:
  - Search seqreq from last+1 upward, modulo 4. The first set bit is granted.
  - On the grant edge: latch dacaddr and dacdata, set dacdav=1, set last=grant, go to SEND.
  - Latency: dacdav rises on the first edge that samples seqreq high.
  - seqreq=0: remain in IDLE.
- SEND:
  - Hold dacdav=1 with dacaddr and dacdata stable.
  - On the edge sampling davdac=1: dacdav<=0, go to RELEASE.
- RELEASE:
  - Wait for davdac=0.
  - On that edge: seqack[grant]<=1 for exactly one cycle. Go to GAP, or to IDLE if GAP=0.
- GAP:
  - Count GAP cycles with seqbusy=1, then go to IDLE.
  - No request is granted during GAP.
- Requests:
  - A request dropped after grant does not abort the transfer. The latched data is sent and seqack still pulses.
  - seqdata changes after grant are ignored.
  - A requester that keeps seqreq high after seqack is re-queued in round-robin order. It cannot starve other channels.
  - Simultaneous requests are resolved by the pointer only.
- Defensive case: davdac already high in IDLE. No grant is issued until davdac=0, and state remains IDLE.
- seqack bits are one-hot or zero; never more than one bit high.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to SEND and to RELEASE.
  - If it reaches TIMEOUT in either state: dacdav<=0, seqerr<=1 (sticky until reset), no seqack, go to GAP.
  - The pointer has already advanced, so the failing channel is retried only in its next round-robin turn.
- Undefined: no counter; SEND and RELEASE wait indefinitely; seqerr tied 0.

Test Plan:
1. seqreq=4'b0100, channel 2 sample=12'hABC, behavioural core acking 66 cycles after dacdav -> daccmd=4'h3, dacaddr=4'h2, dacdata=12'hABC held for the whole SEND; dacdav drops one cycle after davdac=1; seqack=4'b0100 for exactly one cycle after davdac falls.
2. seqreq=4'b1111 held, samples 12'h001/002/003/004 -> service order 0,1,2,3,0; each frame separated by exactly GAP=2 idle cycles; seqbusy low only between bursts if requests stop.
3. After channel 1 is served, assert seqreq=4'b0011 -> channel 0 granted next (search from 2 wraps to 0), then channel 1.
4. Drop seqreq[3] one cycle after grant, change its data to 12'hFFF -> original latched sample is sent; seqack[3] still pulses.
5. Assert seqreset mid-SEND -> dacdav=0 in the same cycle, before any clock edge; all outputs at reset values; the next request gets a full clean frame.
6. SEQ_TIMEOUT_EN defined, core never acks, TIMEOUT=200 -> dacdav drops 200 cycles after rising; seqerr=1 and stays set; no seqack; the next channel is granted after GAP.
